// File: rtl/ifetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_prefetch_buffer
// Description : Instruction prefetch queue that fetches aligned 8-byte words
//               ahead of the fetch PC and presents a 10-byte window at pc_in.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_prefetch_buffer #(
    parameter int DEPTH_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] pc_in,
    output logic        ibytes_valid,
    output logic [79:0] ibytes,
    output logic        imem_error,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err
);

    localparam int CAP = 8 * DEPTH_WORDS;
    localparam int CW  = $clog2(CAP + 1);
    localparam int OW  = CW + 1;
    localparam logic [CW-1:0] C_WORD   = CW'(8);
    localparam logic [CW-1:0] C_CAP_M8 = CW'(CAP - 8);

    logic [63:0]   base_q, base_d;
    logic [CW-1:0] count_q, count_d;
    logic          outstanding_q, outstanding_d;
    logic          discard_q, discard_d;
    logic          err_valid_q, err_valid_d;
    logic [63:0]   err_addr_q, err_addr_d;
    logic [63:0]   mem_addr_q, mem_addr_d;
    logic [63:0]   data_q [DEPTH_WORDS];
    logic [63:0]   data_d [DEPTH_WORDS];

    logic [63:0]     w_limit;
    logic [63:0]     w_off64;
    logic [OW-1:0]   w_off;
    logic            w_hit;
    logic            w_retire;
    logic            w_append;
    logic [CW-1:0]   w_count_ret;
    logic [CAP*8-1:0] w_flat;
    logic [79:0]     w_bytes_raw;

    // Buffered range includes the word currently in flight, so a PC that is
    // about to be filled does not trigger a flush.
    assign w_limit  = base_q + 64'(count_q) + (outstanding_q ? 64'd8 : 64'd0);
    assign w_hit    = (pc_in >= base_q) && (pc_in < w_limit);
    assign w_off64  = pc_in - base_q;
    assign w_off    = w_hit ? w_off64[OW-1:0] : '0;
    assign w_retire = w_hit && (w_off64 >= 64'd8) && (count_q >= C_WORD);
    assign w_append = mem_ack && outstanding_q && !discard_q;
    assign w_count_ret = w_retire ? (count_q - C_WORD) : count_q;

    always_comb begin
        base_d        = base_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        err_valid_d   = err_valid_q;
        err_addr_d    = err_addr_q;
        mem_addr_d    = mem_addr_q;
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            data_d[i] = data_q[i];
        end

        if (!w_hit) begin
            base_d        = {pc_in[63:3], 3'b000};
            count_d       = '0;
            err_valid_d   = 1'b0;
            outstanding_d = outstanding_q && !mem_ack;
            discard_d     = outstanding_q && !mem_ack;
        end else begin
            if (w_retire) begin
                base_d = base_q + 64'd8;
                for (int i = 0; i < DEPTH_WORDS - 1; i++) begin
                    data_d[i] = data_q[i + 1];
                end
            end
            // Append lands after the retire shift, at the post-retire tail.
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                if (w_append && (w_count_ret[CW-1:3] == (CW-3)'(i))) begin
                    data_d[i] = mem_rdata;
                end
            end
            count_d = w_append ? (w_count_ret + C_WORD) : w_count_ret;
            if (w_append && mem_err) begin
                err_valid_d = 1'b1;
                err_addr_d  = mem_addr_q;
            end
            if (mem_ack) begin
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end
        end

        if (!outstanding_d && !err_valid_d && (count_d <= C_CAP_M8)) begin
            outstanding_d = 1'b1;
            mem_addr_d    = base_d + 64'(count_d);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q        <= '0;
            count_q       <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            err_valid_q   <= 1'b0;
            err_addr_q    <= '0;
            mem_addr_q    <= '0;
        end else begin
            base_q        <= base_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            err_valid_q   <= err_valid_d;
            err_addr_q    <= err_addr_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    // Payload needs no reset: count gates every byte that can be observed.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            data_q[i] <= data_d[i];
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH_WORDS; g++) begin : g_flat
            assign w_flat[64*g +: 64] = data_q[g];
        end
    endgenerate

    always_comb begin
        w_bytes_raw = '0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CAP; j++) begin
                if (w_hit && ((w_off + OW'(k)) == OW'(j)) &&
                    ((w_off + OW'(k)) < {1'b0, count_q})) begin
                    w_bytes_raw[8*k +: 8] = w_flat[8*j +: 8];
                end
            end
        end
    end

    assign imem_error   = err_valid_q && ((pc_in + 64'd10) > err_addr_q) &&
                          (pc_in < (err_addr_q + 64'd8));
    assign ibytes_valid = (w_hit && ((pc_in + 64'd10) <= (base_q + 64'(count_q)))) ||
                          imem_error;
    assign ibytes       = ibytes_valid ? w_bytes_raw : '0;
    assign mem_req      = outstanding_q;
    assign mem_addr     = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_prefetch_buffer
// Description : Self-checking bench with a behavioural instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch_buffer;

    localparam int DW  = 4;
    localparam int CAP = 8 * DW;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc_in = '0;
    logic        ibytes_valid;
    logic [79:0] ibytes;
    logic        imem_error;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        mem_err = 1'b0;

    int total = 0;
    int bad   = 0;

    bit          auto_en   = 1'b1;
    bit          stale_req = 1'b0;
    bit          hold_en   = 1'b0;
    bit          err_en    = 1'b0;
    logic [63:0] hold_addr = '0;
    logic [63:0] err_inj   = '0;
    int          lat_max   = 0;
    bit          busy      = 1'b0;
    int          cnt       = 0;
    logic [63:0] issued [$];

    ifetch_prefetch_buffer #(.DEPTH_WORDS(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc_in       (pc_in),
        .ibytes_valid(ibytes_valid),
        .ibytes      (ibytes),
        .imem_error  (imem_error),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] mbyte(input logic [63:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (lo * 8'd29) ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [63:0] mword(input logic [63:0] a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mbyte(a + 64'(i));
        return r;
    endfunction

    function automatic logic [79:0] mwin(input logic [63:0] pc);
        logic [79:0] r;
        for (int k = 0; k < 10; k++) r[8*k +: 8] = mbyte(pc + 64'(k));
        return r;
    endfunction

    // Memory: each request is answered after 0..lat_max extra cycles.
    always @(negedge clock) begin
        mem_ack = 1'b0;
        mem_err = 1'b0;
        if (!auto_en) begin
            busy = 1'b0;
            if (stale_req) begin
                mem_ack   = 1'b1;
                mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
            end
        end else if (!mem_req) begin
            busy = 1'b0;
        end else begin
            if (!busy) begin
                busy = 1'b1;
                cnt  = $urandom_range(lat_max, 0);
                issued.push_back(mem_addr);
            end
            if (!(hold_en && mem_addr == hold_addr)) begin
                if (cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mword(mem_addr);
                    mem_err   = err_en && (mem_addr == err_inj);
                    busy      = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] pc);
        reset = 1'b1; pc_in = pc; auto_en = 1'b1; stale_req = 1'b0;
        hold_en = 1'b0; err_en = 1'b0; lat_max = 0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(64'h0);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
        total++; if (mem_addr !== 64'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        total++; if (ibytes_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ibytes_valid); end
        total++; if (ibytes !== 80'h0) begin bad++; $display("FAIL reset_ibytes got=%h want=0", ibytes); end
        total++; if (imem_error !== 1'b0) begin bad++; $display("FAIL reset_imem_error got=%b want=0", imem_error); end
    endtask

    task automatic test_cold_start;
        tick;
        total++; if (mem_req !== 1'b1 || mem_addr !== 64'h0) begin bad++; $display("FAIL cold_req0 got=%b/%h want=1/0", mem_req, mem_addr); end
        tick;
        total++; if (mem_req !== 1'b1 || mem_addr !== 64'h8) begin bad++; $display("FAIL cold_req1 got=%b/%h want=1/8", mem_req, mem_addr); end
        total++; if (ibytes_valid !== 1'b0) begin bad++; $display("FAIL cold_early_valid got=%b want=0", ibytes_valid); end
        tick;
        total++; if (ibytes_valid !== 1'b1) begin bad++; $display("FAIL cold_valid got=%b want=1", ibytes_valid); end
        total++; if (ibytes !== mwin(64'h0)) begin bad++; $display("FAIL cold_bytes got=%h want=%h", ibytes, mwin(64'h0)); end
    endtask

    task automatic test_stream;
        int first;
        first   = issued.size();
        lat_max = 3;
        for (int c = 0; c < 400; c++) begin
            if (ibytes_valid) begin
                total++; if (ibytes !== mwin(pc_in)) begin bad++; $display("FAIL stream_bytes pc=%h got=%h want=%h", pc_in, ibytes, mwin(pc_in)); end
            end
            if (mem_req) begin
                total++;
                if ((mem_addr - {pc_in[63:3], 3'b000}) > 64'(CAP - 8)) begin
                    bad++; $display("FAIL stream_occupancy pc=%h req=%h", pc_in, mem_addr);
                end
            end
            if (ibytes_valid && $urandom_range(3, 0) != 0) pc_in = pc_in + 64'd10;
            tick;
        end
        total++; if (pc_in < 64'h180) begin bad++; $display("FAIL stream_progress got=%h want>=180", pc_in); end
        for (int i = first; i < issued.size(); i++) begin
            total++;
            if (issued[i] !== 64'h10 + 64'(8 * (i - first))) begin
                bad++; $display("FAIL stream_addr idx=%0d got=%h want=%h", i - first, issued[i], 64'h10 + 64'(8 * (i - first)));
            end
        end
        lat_max = 0;
    endtask

    task automatic test_redirect;
        bit found;
        do_reset(64'h20);
        hold_en = 1'b1; hold_addr = 64'h38;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick;
            if (mem_req && mem_addr == 64'h38) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL redir_wait_38 got=%h want=38", mem_addr); end
        total++; if (ibytes_valid !== 1'b1 || ibytes !== mwin(64'h20)) begin bad++; $display("FAIL redir_pre_bytes got=%b/%h want=1/%h", ibytes_valid, ibytes, mwin(64'h20)); end
        pc_in = 64'h103;
        tick;
        total++; if (mem_req !== 1'b1 || mem_addr !== 64'h38) begin bad++; $display("FAIL redir_held got=%b/%h want=1/38", mem_req, mem_addr); end
        hold_en = 1'b0;
        tick;
        total++; if (mem_req !== 1'b1 || mem_addr !== 64'h100) begin bad++; $display("FAIL redir_new_req got=%b/%h want=1/100", mem_req, mem_addr); end
        tick;
        total++; if (ibytes_valid !== 1'b0) begin bad++; $display("FAIL redir_early_valid got=%b want=0", ibytes_valid); end
        tick;
        total++; if (ibytes_valid !== 1'b1 || ibytes !== mwin(64'h103)) begin bad++; $display("FAIL redir_bytes got=%b/%h want=1/%h", ibytes_valid, ibytes, mwin(64'h103)); end
    endtask

    task automatic test_unaligned;
        do_reset(64'h0E);
        tick;
        total++; if (mem_addr !== 64'h8) begin bad++; $display("FAIL unal_first_req got=%h want=8", mem_addr); end
        tick;
        total++; if (ibytes_valid !== 1'b0) begin bad++; $display("FAIL unal_early got=%b want=0", ibytes_valid); end
        tick;
        total++; if (ibytes_valid !== 1'b1 || ibytes !== mwin(64'h0E)) begin bad++; $display("FAIL unal_bytes got=%b/%h want=1/%h", ibytes_valid, ibytes, mwin(64'h0E)); end
        do_reset(64'h0F);
        tick; tick; tick;
        total++; if (ibytes_valid !== 1'b0) begin bad++; $display("FAIL off7_early got=%b want=0", ibytes_valid); end
        tick;
        total++; if (ibytes_valid !== 1'b1 || ibytes !== mwin(64'h0F)) begin bad++; $display("FAIL off7_bytes got=%b/%h want=1/%h", ibytes_valid, ibytes, mwin(64'h0F)); end
    endtask

    task automatic test_error;
        do_reset(64'h12);
        err_en = 1'b1; err_inj = 64'h18;
        tick; tick; tick;
        total++; if (imem_error !== 1'b1) begin bad++; $display("FAIL err_flag got=%b want=1", imem_error); end
        total++; if (ibytes_valid !== 1'b1 || ibytes !== mwin(64'h12)) begin bad++; $display("FAIL err_bytes got=%b/%h want=1/%h", ibytes_valid, ibytes, mwin(64'h12)); end
        for (int i = 0; i < 6; i++) begin
            total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL err_no_req cyc=%0d got=%b want=0", i, mem_req); end
            tick;
        end
        err_en = 1'b0;
        pc_in = 64'h40;
        tick;
        total++; if (imem_error !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", imem_error); end
        total++; if (mem_req !== 1'b1 || mem_addr !== 64'h40) begin bad++; $display("FAIL err_reissue got=%b/%h want=1/40", mem_req, mem_addr); end
    endtask

    task automatic test_error_partial;
        logic [79:0] exp;
        do_reset(64'h44);
        err_en = 1'b1; err_inj = 64'h40;
        tick; tick;
        exp = '0;
        for (int k = 0; k < 10; k++) begin
            if (64'h44 + 64'(k) < 64'h48) exp[8*k +: 8] = mbyte(64'h44 + 64'(k));
        end
        total++; if (imem_error !== 1'b1 || ibytes_valid !== 1'b1) begin bad++; $display("FAIL perr_flags got=%b/%b want=1/1", imem_error, ibytes_valid); end
        total++; if (ibytes !== exp) begin bad++; $display("FAIL perr_bytes got=%h want=%h", ibytes, exp); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL perr_no_req got=%b want=0", mem_req); end
        err_en = 1'b0;
    endtask

    task automatic test_async_reset;
        do_reset(64'h80);
        hold_en = 1'b1; hold_addr = 64'h90;
        tick; tick; tick;
        total++; if (mem_req !== 1'b1 || ibytes_valid !== 1'b1) begin bad++; $display("FAIL ares_pre got=%b/%b want=1/1", mem_req, ibytes_valid); end
        #2 reset = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0 || mem_addr !== 64'h0) begin bad++; $display("FAIL ares_req got=%b/%h want=0/0", mem_req, mem_addr); end
        total++; if (ibytes_valid !== 1'b0 || ibytes !== 80'h0 || imem_error !== 1'b0) begin bad++; $display("FAIL ares_window got=%b/%h/%b want=0/0/0", ibytes_valid, ibytes, imem_error); end
        hold_en = 1'b0; auto_en = 1'b0;
        tick; tick;
        reset = 1'b0; stale_req = 1'b1;
        tick;
        total++; if (mem_req !== 1'b1 || mem_addr !== 64'h80) begin bad++; $display("FAIL ares_stale_req got=%b/%h want=1/80", mem_req, mem_addr); end
        stale_req = 1'b0; auto_en = 1'b1;
        tick;
        total++; if (ibytes_valid !== 1'b0) begin bad++; $display("FAIL ares_stale_count got=%b want=0", ibytes_valid); end
        tick;
        total++; if (ibytes_valid !== 1'b1 || ibytes !== mwin(64'h80)) begin bad++; $display("FAIL ares_bytes got=%b/%h want=1/%h", ibytes_valid, ibytes, mwin(64'h80)); end
    endtask

    initial begin
        test_reset;
        test_cold_start;
        test_stream;
        test_redirect;
        test_unaligned;
        test_error;
        test_error_partial;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
